imem_loader: RTL



---
 rtl/imem_loader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction memory for the single-cycle core with a byte-stream boot loader.
// Holds the core in reset until a big-endian program image has been written into the word array.
module imem_loader #(
    parameter int width = 32,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] PC,
    output logic [width-1:0] Instr,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             core_rst_n,
    output logic             load_done,
    output logic             load_err
);

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        LOAD,
        DONE,
        ERR
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [1:0]         lane_q, lane_d;
    logic [width-9:0]   asm_q, asm_d;
    logic [width-1:0]   mem_q [DEPTH];

    logic               accept;
    logic               wr_en;
    logic [width-1:0]   wr_word;
    logic [15:0]        hdr_n;
    logic               last_word;
    logic               core_rst_n_q, load_done_q, load_err_q;
    logic               unused_pc;

    assign byte_ready = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == LOAD);
    assign accept     = byte_valid && byte_ready;
    assign hdr_n      = {cnt_q[15:8], byte_in};
    // Byte 3 of a word is written straight from the input, so only three bytes are buffered.
    assign wr_word    = {asm_q, byte_in};
    assign last_word  = ({{(16-AW){1'b0}}, idx_q} == (cnt_q - 16'd1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        asm_d   = asm_q;
        wr_en   = 1'b0;
        case (state_q)
            HDR_HI: begin
                if (accept) begin
                    cnt_d[15:8] = byte_in;
                    state_d     = HDR_LO;
                end
            end
            HDR_LO: begin
                if (accept) begin
                    cnt_d = hdr_n;
                    if (hdr_n == 16'd0 || hdr_n > 16'(DEPTH)) begin
                        state_d = ERR;
                    end else begin
                        state_d = LOAD;
                        idx_d   = '0;
                        lane_d  = 2'd0;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    asm_d  = {asm_q[width-17:0], byte_in};
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        wr_en = 1'b1;
                        idx_d = idx_q + 1'b1;
                        if (last_word) state_d = DONE;
                    end
                end
            end
            DONE:    state_d = DONE;
            ERR:     state_d = ERR;
            default: state_d = HDR_HI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HDR_HI;
            cnt_q   <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
        end
    end

    // Whole array clears on reset so an aborted load never leaves stale code behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[idx_q] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_rst_n_q <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            core_rst_n_q <= (state_d == DONE);
            load_done_q  <= (state_d == DONE);
            load_err_q   <= (state_d == ERR);
        end
    end

    assign core_rst_n = core_rst_n_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;

    // Byte offset and bits above the array are don't-care: the fetch address wraps.
    assign Instr      = mem_q[PC[AW+1:2]];
    assign unused_pc  = ^{PC[width-1:AW+2], PC[1:0]};

endmodule
